// File: rtl/monitorizacion_baterias_n.sv
// -----------------------------------------------------------------------------
// monitorizacion_baterias_n
// N-battery charge monitor. On every valid strobe the packed charge levels are
// summed and classified into a four-level pack status, each battery gets a
// hysteresis + persistence filtered low-charge warning, and entering the
// critical status latches an alarm that software acknowledges.
//
// Parameters:
//   N_BAT      number of batteries (>=2)
//   ANCHO      bits per charge reading
//   UMBRAL_ADV warning sets when charge < UMBRAL_ADV
//   HIST       warning clears when charge >= UMBRAL_ADV+HIST
//   FILTRO     consecutive qualifying valid samples per change (>=1)
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   muestra_valida    cargas valid this cycle
//   cargas            packed charges, battery i at [i*ANCHO +: ANCHO]
//   ack_alarma        acknowledge for alarma_critica
//   advertencia       per-battery filtered low-charge warning
//   optimo/aceptable/regular/critico  one-hot pack status
//   suma_total        sum of the last valid sample
//   alarma_critica    latched alarm, set on entry into critico
//   conteo_critico    saturating count of entries into critico
//
// Optional feature macro: MONITOR_CONTEO_CRITICO_EN enables conteo_critico;
// without it the port is tied to zero.
// -----------------------------------------------------------------------------
module monitorizacion_baterias_n #(
    parameter int N_BAT      = 2,
    parameter int ANCHO      = 4,
    parameter int UMBRAL_ADV = 4,
    parameter int HIST       = 2,
    parameter int FILTRO     = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              muestra_valida,
    input  logic [N_BAT*ANCHO-1:0]            cargas,
    input  logic                              ack_alarma,
    output logic [N_BAT-1:0]                  advertencia,
    output logic                              optimo,
    output logic                              aceptable,
    output logic                              regular,
    output logic                              critico,
    output logic [ANCHO+$clog2(N_BAT)-1:0]    suma_total,
    output logic                              alarma_critica,
    output logic [7:0]                        conteo_critico
);

    localparam int SW  = ANCHO + $clog2(N_BAT);
    // Three extra bits hold 3*MAX and 4*S without overflow.
    localparam int CW  = SW + 3;
    localparam int RW  = $clog2(FILTRO + 1);
    localparam int MAX = N_BAT * ((1 << ANCHO) - 1);

    localparam logic [CW-1:0]    MAX1     = CW'(MAX);
    localparam logic [CW-1:0]    MAX2     = CW'(2 * MAX);
    localparam logic [CW-1:0]    MAX3     = CW'(3 * MAX);
    localparam logic [ANCHO+1:0] UMB_SET  = (ANCHO+2)'(UMBRAL_ADV);
    localparam logic [ANCHO+1:0] UMB_CLR  = (ANCHO+2)'(UMBRAL_ADV + HIST);
    localparam logic [RW-1:0]    FILTRO_C = RW'(FILTRO);
    localparam logic [RW-1:0]    UNO      = RW'(1);

    typedef enum logic [1:0] {
        ST_OPTIMO    = 2'd0,
        ST_ACEPTABLE = 2'd1,
        ST_REGULAR   = 2'd2,
        ST_CRITICO   = 2'd3
    } estado_t;

    // Quartile classification of a pack sum against the full-scale MAX.
    function automatic estado_t clasificar(input logic [SW-1:0] s);
        logic [CW-1:0] s4;
        s4 = {1'b0, s, 2'b00};
        if (s4 >= MAX3) begin
            return ST_OPTIMO;
        end else if (s4 >= MAX2) begin
            return ST_ACEPTABLE;
        end else if (s4 >= MAX1) begin
            return ST_REGULAR;
        end else begin
            return ST_CRITICO;
        end
    endfunction

    logic [SW-1:0]  suma_s;
    estado_t        clase_s;
    estado_t        estado_r, estado_s;
    estado_t        cand_r, cand_s;
    logic [RW-1:0]  run_r, run_s, run_inc_s;
    logic [RW-1:0]  cnt_adv_r [N_BAT];
    logic [RW-1:0]  cnt_adv_s [N_BAT];
    logic [N_BAT-1:0] adv_s;
    logic           entrada_crit_s;
    logic           alarma_s;

    // Sum of all battery charges in full width.
    always_comb begin
        suma_s = '0;
        for (int i = 0; i < N_BAT; i++) begin
            suma_s = suma_s + SW'(cargas[i*ANCHO +: ANCHO]);
        end
        clase_s = clasificar(suma_s);
    end

    // Per-battery warning filter: the qualifying condition depends on the
    // current warning, which is what gives the hysteresis band.
    always_comb begin
        adv_s = advertencia;
        for (int i = 0; i < N_BAT; i++) begin
            cnt_adv_s[i] = cnt_adv_r[i];
            if (muestra_valida) begin
                if (advertencia[i] ? ({2'b00, cargas[i*ANCHO +: ANCHO]} >= UMB_CLR)
                                   : ({2'b00, cargas[i*ANCHO +: ANCHO]} <  UMB_SET)) begin
                    if ((cnt_adv_r[i] + UNO) == FILTRO_C) begin
                        adv_s[i]     = ~advertencia[i];
                        cnt_adv_s[i] = '0;
                    end else begin
                        cnt_adv_s[i] = cnt_adv_r[i] + UNO;
                    end
                end else begin
                    cnt_adv_s[i] = '0;
                end
            end else begin
                cnt_adv_s[i] = cnt_adv_r[i];
            end
        end
    end

    // Status FSM next-state: a candidate must persist for FILTRO valid samples.
    always_comb begin
        estado_s  = estado_r;
        cand_s    = cand_r;
        run_s     = run_r;
        run_inc_s = UNO;
        if (muestra_valida) begin
            if (clase_s == estado_r) begin
                run_s = '0;
            end else begin
                cand_s = clase_s;
                if (clase_s == cand_r) begin
                    run_inc_s = run_r + UNO;
                end else begin
                    run_inc_s = UNO;
                end
                if (run_inc_s == FILTRO_C) begin
                    estado_s = clase_s;
                    run_s    = '0;
                end else begin
                    run_s = run_inc_s;
                end
            end
        end else begin
            run_s = run_r;
        end
    end

    // Alarm next value: entry into critico wins over an acknowledge.
    always_comb begin
        entrada_crit_s = (estado_s == ST_CRITICO) && (estado_r != ST_CRITICO);
        alarma_s       = alarma_critica;
        if (entrada_crit_s) begin
            alarma_s = 1'b1;
        end else if (ack_alarma && (estado_r != ST_CRITICO)) begin
            alarma_s = 1'b0;
        end else begin
            alarma_s = alarma_critica;
        end
    end

    // Status FSM state, candidate and run registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r <= ST_CRITICO;
            cand_r   <= ST_CRITICO;
            run_r    <= '0;
        end else begin
            estado_r <= estado_s;
            cand_r   <= cand_s;
            run_r    <= run_s;
        end
    end

    // Registered outputs and warning filter counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            advertencia    <= '0;
            optimo         <= 1'b0;
            aceptable      <= 1'b0;
            regular        <= 1'b0;
            critico        <= 1'b1;
            suma_total     <= '0;
            alarma_critica <= 1'b0;
            for (int i = 0; i < N_BAT; i++) begin
                cnt_adv_r[i] <= '0;
            end
        end else begin
            advertencia    <= adv_s;
            optimo         <= (estado_s == ST_OPTIMO);
            aceptable      <= (estado_s == ST_ACEPTABLE);
            regular        <= (estado_s == ST_REGULAR);
            critico        <= (estado_s == ST_CRITICO);
            alarma_critica <= alarma_s;
            if (muestra_valida) begin
                suma_total <= suma_s;
            end else begin
                suma_total <= suma_total;
            end
            for (int i = 0; i < N_BAT; i++) begin
                cnt_adv_r[i] <= cnt_adv_s[i];
            end
        end
    end

`ifdef MONITOR_CONTEO_CRITICO_EN
    // Saturating count of transitions into critico.
    always_ff @(posedge clk) begin
        if (rst) begin
            conteo_critico <= 8'd0;
        end else if (entrada_crit_s && (conteo_critico != 8'd255)) begin
            conteo_critico <= conteo_critico + 8'd1;
        end else begin
            conteo_critico <= conteo_critico;
        end
    end
`else
    assign conteo_critico = 8'd0;
`endif

endmodule

// File: tb/tb_monitorizacion_baterias_n.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for monitorizacion_baterias_n, default
// parameters (N_BAT=2, ANCHO=4, UMBRAL_ADV=4, HIST=2, FILTRO=3, MAX=30).
// Stimulus is applied #1 after a rising edge and outputs are read #1 after
// the edge that accepts the sample.
// -----------------------------------------------------------------------------
module tb_monitorizacion_baterias_n;

`ifdef MONITOR_CONTEO_CRITICO_EN
    localparam int CE = 1;
`else
    localparam int CE = 0;
`endif

    localparam logic [3:0] OPT = 4'b1000;
    localparam logic [3:0] ACE = 4'b0100;
    localparam logic [3:0] REG = 4'b0010;
    localparam logic [3:0] CRI = 4'b0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       muestra_valida;
    logic [7:0] cargas;
    logic       ack_alarma;
    logic [1:0] advertencia;
    logic       optimo, aceptable, regular, critico;
    logic [4:0] suma_total;
    logic       alarma_critica;
    logic [7:0] conteo_critico;
    logic [3:0] st;

    int n_cmp  = 0;
    int n_fail = 0;

    assign st = {optimo, aceptable, regular, critico};

    monitorizacion_baterias_n dut (
        .clk            (clk),
        .rst            (rst),
        .muestra_valida (muestra_valida),
        .cargas         (cargas),
        .ack_alarma     (ack_alarma),
        .advertencia    (advertencia),
        .optimo         (optimo),
        .aceptable      (aceptable),
        .regular        (regular),
        .critico        (critico),
        .suma_total     (suma_total),
        .alarma_critica (alarma_critica),
        .conteo_critico (conteo_critico)
    );

    always #5 clk = ~clk;

    // One valid sample: battery 0 charge b0, battery 1 charge b1.
    task automatic send(input logic [3:0] b0, input logic [3:0] b1);
        cargas = {b1, b0};
        muestra_valida = 1'b1;
        @(posedge clk);
        #1;
        muestra_valida = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_rst();
        n_cmp++; if (advertencia !== 2'b00) begin n_fail++; $display("FAIL reset_adv: got %b want 00", advertencia); end
        n_cmp++; if (st !== CRI) begin n_fail++; $display("FAIL reset_state: got %b want %b", st, CRI); end
        n_cmp++; if (suma_total !== 5'd0) begin n_fail++; $display("FAIL reset_suma: got %0d want 0", suma_total); end
        n_cmp++; if (alarma_critica !== 1'b0) begin n_fail++; $display("FAIL reset_alarm: got %b want 0", alarma_critica); end
        n_cmp++; if (conteo_critico !== 8'd0) begin n_fail++; $display("FAIL reset_conteo: got %0d want 0", conteo_critico); end
    endtask

    task automatic test_warn_set();
        send(4'd0, 4'd0);
        send(4'd0, 4'd0);
        n_cmp++; if (advertencia !== 2'b00) begin n_fail++; $display("FAIL warn_after2: got %b want 00", advertencia); end
        send(4'd0, 4'd0);
        n_cmp++; if (advertencia !== 2'b11) begin n_fail++; $display("FAIL warn_after3: got %b want 11", advertencia); end
        n_cmp++; if (st !== CRI) begin n_fail++; $display("FAIL warn_state: got %b want %b", st, CRI); end
        n_cmp++; if (alarma_critica !== 1'b0) begin n_fail++; $display("FAIL warn_alarm: got %b want 0", alarma_critica); end
        n_cmp++; if (suma_total !== 5'd0) begin n_fail++; $display("FAIL warn_suma: got %0d want 0", suma_total); end
    endtask

    task automatic test_optimo();
        send(4'd15, 4'd15);
        n_cmp++; if (suma_total !== 5'd30) begin n_fail++; $display("FAIL opt_suma: got %0d want 30", suma_total); end
        send(4'd15, 4'd15);
        n_cmp++; if (st !== CRI) begin n_fail++; $display("FAIL opt_after2: got %b want %b", st, CRI); end
        send(4'd15, 4'd15);
        n_cmp++; if (st !== OPT) begin n_fail++; $display("FAIL opt_after3: got %b want %b", st, OPT); end
        n_cmp++; if (advertencia !== 2'b00) begin n_fail++; $display("FAIL opt_adv: got %b want 00", advertencia); end
    endtask

    task automatic test_broken_runs();
        send(4'd15, 4'd15);
        send(4'd0, 4'd0);
        send(4'd15, 4'd15);
        send(4'd0, 4'd0);
        send(4'd0, 4'd0);
        n_cmp++; if (st !== OPT) begin n_fail++; $display("FAIL runs_hold: got %b want %b", st, OPT); end
        n_cmp++; if (advertencia !== 2'b00) begin n_fail++; $display("FAIL runs_adv: got %b want 00", advertencia); end
        send(4'd0, 4'd0);
        n_cmp++; if (st !== CRI) begin n_fail++; $display("FAIL runs_crit: got %b want %b", st, CRI); end
        n_cmp++; if (alarma_critica !== 1'b1) begin n_fail++; $display("FAIL runs_alarm: got %b want 1", alarma_critica); end
        n_cmp++; if (conteo_critico !== 8'(CE)) begin n_fail++; $display("FAIL runs_conteo: got %0d want %0d", conteo_critico, CE); end
        n_cmp++; if (advertencia !== 2'b11) begin n_fail++; $display("FAIL runs_adv3: got %b want 11", advertencia); end
        send(4'd0, 4'd0);
        n_cmp++; if (st !== CRI) begin n_fail++; $display("FAIL runs_stay: got %b want %b", st, CRI); end
    endtask

    task automatic test_alarm();
        ack_alarma = 1'b1;
        idle();
        ack_alarma = 1'b0;
        n_cmp++; if (alarma_critica !== 1'b1) begin n_fail++; $display("FAIL alarm_ack_crit: got %b want 1", alarma_critica); end
        send(4'd8, 4'd0);
        send(4'd8, 4'd0);
        send(4'd8, 4'd0);
        n_cmp++; if (st !== REG) begin n_fail++; $display("FAIL alarm_regular: got %b want %b", st, REG); end
        n_cmp++; if (advertencia !== 2'b10) begin n_fail++; $display("FAIL alarm_adv: got %b want 10", advertencia); end
        n_cmp++; if (suma_total !== 5'd8) begin n_fail++; $display("FAIL alarm_suma: got %0d want 8", suma_total); end
        n_cmp++; if (alarma_critica !== 1'b1) begin n_fail++; $display("FAIL alarm_held: got %b want 1", alarma_critica); end
        ack_alarma = 1'b1;
        idle();
        ack_alarma = 1'b0;
        n_cmp++; if (alarma_critica !== 1'b0) begin n_fail++; $display("FAIL alarm_cleared: got %b want 0", alarma_critica); end
    endtask

    task automatic test_hysteresis();
        for (int k = 0; k < 3; k++) send(4'd0, 4'd0);
        n_cmp++; if (advertencia !== 2'b11) begin n_fail++; $display("FAIL hyst_warned: got %b want 11", advertencia); end
        n_cmp++; if (st !== CRI) begin n_fail++; $display("FAIL hyst_crit: got %b want %b", st, CRI); end
        n_cmp++; if (alarma_critica !== 1'b1) begin n_fail++; $display("FAIL hyst_alarm: got %b want 1", alarma_critica); end
        n_cmp++; if (conteo_critico !== 8'(2*CE)) begin n_fail++; $display("FAIL hyst_conteo: got %0d want %0d", conteo_critico, 2*CE); end
        for (int k = 0; k < 5; k++) send(4'd5, 4'd0);
        n_cmp++; if (advertencia !== 2'b11) begin n_fail++; $display("FAIL hyst_band: got %b want 11", advertencia); end
        send(4'd6, 4'd0);
        send(4'd6, 4'd0);
        send(4'd5, 4'd0);
        n_cmp++; if (advertencia !== 2'b11) begin n_fail++; $display("FAIL hyst_broken: got %b want 11", advertencia); end
        send(4'd6, 4'd0);
        send(4'd6, 4'd0);
        n_cmp++; if (advertencia !== 2'b11) begin n_fail++; $display("FAIL hyst_clr2: got %b want 11", advertencia); end
        send(4'd6, 4'd0);
        n_cmp++; if (advertencia !== 2'b10) begin n_fail++; $display("FAIL hyst_clr3: got %b want 10", advertencia); end
        for (int k = 0; k < 3; k++) send(4'd12, 4'd3);
        n_cmp++; if (st !== ACE) begin n_fail++; $display("FAIL hyst_aceptable: got %b want %b", st, ACE); end
        n_cmp++; if (suma_total !== 5'd15) begin n_fail++; $display("FAIL hyst_suma: got %0d want 15", suma_total); end
        n_cmp++; if (advertencia !== 2'b10) begin n_fail++; $display("FAIL hyst_adv_end: got %b want 10", advertencia); end
    endtask

    task automatic test_reset_mid();
        send(4'd15, 4'd15);
        send(4'd15, 4'd15);
        pulse_rst();
        n_cmp++; if (st !== CRI) begin n_fail++; $display("FAIL mid_state: got %b want %b", st, CRI); end
        n_cmp++; if (advertencia !== 2'b00) begin n_fail++; $display("FAIL mid_adv: got %b want 00", advertencia); end
        n_cmp++; if (suma_total !== 5'd0) begin n_fail++; $display("FAIL mid_suma: got %0d want 0", suma_total); end
        n_cmp++; if (alarma_critica !== 1'b0) begin n_fail++; $display("FAIL mid_alarm: got %b want 0", alarma_critica); end
        n_cmp++; if (conteo_critico !== 8'd0) begin n_fail++; $display("FAIL mid_conteo: got %0d want 0", conteo_critico); end
        send(4'd15, 4'd15);
        send(4'd15, 4'd15);
        n_cmp++; if (st !== CRI) begin n_fail++; $display("FAIL mid_after2: got %b want %b", st, CRI); end
        send(4'd15, 4'd15);
        n_cmp++; if (st !== OPT) begin n_fail++; $display("FAIL mid_after3: got %b want %b", st, OPT); end
    endtask

    task automatic test_idle_interleave();
        pulse_rst();
        send(4'd15, 4'd15);
        idle();
        idle();
        n_cmp++; if (suma_total !== 5'd30) begin n_fail++; $display("FAIL idle_suma: got %0d want 30", suma_total); end
        send(4'd15, 4'd15);
        idle();
        n_cmp++; if (st !== CRI) begin n_fail++; $display("FAIL idle_after2: got %b want %b", st, CRI); end
        send(4'd15, 4'd15);
        n_cmp++; if (st !== OPT) begin n_fail++; $display("FAIL idle_after3: got %b want %b", st, OPT); end
        n_cmp++; if (alarma_critica !== 1'b0) begin n_fail++; $display("FAIL idle_alarm: got %b want 0", alarma_critica); end
    endtask

    initial begin
        rst            = 1'b1;
        muestra_valida = 1'b0;
        cargas         = 8'd0;
        ack_alarma     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_warn_set();
        test_optimo();
        test_broken_runs();
        test_alarm();
        test_hysteresis();
        test_reset_mid();
        test_idle_interleave();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
